transfer_scheduler: RTL

- Sequences the interface unit's address generator and shares it among N_REQ transfer requesters: filter load, ifmap load, and psum load/write-back.
- Round-robin arbitration picks one requester.
- The winner's base address, length and direction are latched.
- The block then drives the generator's enable/transfer/increment/direct_back_path controls beat by beat and signals per-requester completion.
- Sits between the GLB-side transfer clients and address_generator.

---
 rtl/transfer_sched_pkg.sv | 17 +
 rtl/transfer_scheduler_rr_arbiter.sv | 34 +++
 rtl/transfer_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/transfer_sched_pkg.sv
// Shared types and defaults for the address-generator transfer scheduler.
package transfer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 12;

    localparam logic DIR_LOAD = 1'b0;
    localparam logic DIR_BACK = 1'b1;

endpackage

// File: rtl/transfer_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index
);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            // One extra bit so ptr+off cannot overflow before the modulo fold
            cand = {1'b0, ptr} + (IW+1)'(off);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                gnt[cand[IW-1:0]] = 1'b1;
                index             = cand[IW-1:0];
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/transfer_scheduler.sv
// Shares the address generator among N_REQ transfer clients: arbitrates, latches the
// winner's request, drives the generator controls beat by beat and pulses completion.
module transfer_scheduler
    import transfer_sched_pkg::*;
#(
    parameter  int N_REQ      = 3,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int LEN_WIDTH  = DEF_LEN_WIDTH,
    localparam int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        core_clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
    input  logic [N_REQ-1:0]            req_dir,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            done,
    input  logic                        beat,
    output logic                        busy,
    output logic                        ag_enable,
    output logic                        ag_transfer,
    output logic                        ag_increment,
    output logic                        ag_direct_back_path,
    output logic [ADDR_WIDTH-1:0]       ag_base_address
);

    state_t                state_reg;
    logic [IW-1:0]         rr_ptr_reg;
    logic [IW-1:0]         owner_reg;
    logic [LEN_WIDTH-1:0]  beat_cnt_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic                  dir_reg;

    logic [N_REQ-1:0]      arb_gnt;
    logic [IW-1:0]         arb_index;
    logic [N_REQ-1:0]      owner_onehot;
    logic [ADDR_WIDTH-1:0] base_arr [N_REQ];
    logic [LEN_WIDTH-1:0]  len_arr  [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign base_arr[gi]     = req_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign len_arr[gi]      = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign owner_onehot[gi] = (owner_reg == IW'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N (N_REQ)
    ) u_arbiter (
        .req   (req),
        .ptr   (rr_ptr_reg),
        .gnt   (arb_gnt),
        .index (arb_index)
    );

    // Only output that follows the datapath in the same cycle
    assign ag_increment = (state_reg == STREAM) && beat;

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state_reg           <= IDLE;
            rr_ptr_reg          <= '0;
            owner_reg           <= '0;
            beat_cnt_reg        <= '0;
            len_reg             <= '0;
            base_reg            <= '0;
            dir_reg             <= DIR_LOAD;
            grant               <= '0;
            done                <= '0;
            busy                <= 1'b0;
            ag_enable           <= 1'b0;
            ag_transfer         <= 1'b0;
            ag_direct_back_path <= 1'b0;
            ag_base_address     <= '0;
        end else begin
            // Output registers present the decode of the state being left this edge
            busy                <= (state_reg != IDLE);
            ag_base_address     <= base_reg;
            ag_direct_back_path <= dir_reg;
            grant               <= '0;
            done                <= '0;
            ag_enable           <= 1'b0;
            ag_transfer         <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|arb_gnt) begin
                        owner_reg <= arb_index;
                        base_reg  <= base_arr[arb_index];
                        len_reg   <= len_arr[arb_index];
                        dir_reg   <= req_dir[arb_index];
                        state_reg <= (len_arr[arb_index] == '0) ? DONE : START;
                    end
                end
                START: begin
                    grant       <= owner_onehot;
                    ag_enable   <= 1'b1;
                    ag_transfer <= 1'b1;
                    state_reg   <= STREAM;
                end
                STREAM: begin
                    grant       <= owner_onehot;
                    ag_enable   <= 1'b1;
                    ag_transfer <= 1'b1;
                    if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);
                        if (beat_cnt_reg == len_reg - LEN_WIDTH'(1)) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    done         <= owner_onehot;
                    beat_cnt_reg <= '0;
                    rr_ptr_reg   <= (owner_reg == IW'(N_REQ - 1)) ? '0 : owner_reg + IW'(1);
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
